// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and default sizing.
package arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int N_REQ_DEF    = 8;
  localparam int IDX_W_DEF    = 3;
  localparam int MAX_HOLD_DEF = 16;
  localparam int CNT_W_DEF    = 5;

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority pick: lowest set request at or above ptr, wrapping past N_REQ-1 to 0.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [2*N_REQ-2:0] dbl;
  logic [IDX_W:0]     base;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // Concatenating req with itself lets a plain slice perform the rotation.
  assign dbl  = {req[N_REQ-2:0], req};
  assign base = {1'b0, ptr};
  assign rot  = dbl[base +: N_REQ];

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  // N_REQ is a power of two, so the add wraps back to the real index for free.
  assign win_idx   = ptr + off;
  assign win_valid = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot registered grant held until done, request drop or hold timeout.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam bit              TO_EN     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
  logic [N_REQ-1:0] grant_next;
  logic [IDX_W-1:0] grant_idx_next;
  logic             timeout_next;

  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [N_REQ-1:0] win_onehot;
  logic             rel_done, rel_drop, rel_to;

  rr_prio_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == IDX_W'(gi));
  end

  assign rel_done = done;
  assign rel_drop = !req[grant_idx];
  assign rel_to   = TO_EN && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    hold_cnt_next  = hold_cnt;
    grant_next     = grant;
    grant_idx_next = grant_idx;
    timeout_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          grant_next     = win_onehot;
          grant_idx_next = win_idx;
          hold_cnt_next  = '0;
          state_next     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rel_done || rel_drop || rel_to) begin
          grant_next   = '0;
          ptr_next     = grant_idx + IDX_W'(1);
          state_next   = ST_IDLE;
          // Flag a forced revoke only when the owner still wanted the resource.
          timeout_next = rel_to && !rel_done && !rel_drop;
        end else begin
          hold_cnt_next = hold_cnt + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      hold_cnt  <= hold_cnt_next;
      grant     <= grant_next;
      grant_idx <= grant_idx_next;
      timeout   <= timeout_next;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: reset, rotation, wrap, request drop, timeout and collisions.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       areset;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter dut (
    .clk         (clk),
    .areset      (areset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check grant, grant_valid, timeout and (when granted) the index of the owner.
  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                            input logic to);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(g != 8'h00));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    if (g != 8'h00) chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    $display("step %-12s grant=%02h idx=%0d valid=%0b timeout=%0b", tag, grant, grant_idx,
             grant_valid, timeout);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] nxt;
    areset = 1'b1;
    req    = 8'hFF;
    done   = 1'b0;

    // 1: reset holds everything low even with all requests up
    repeat (2) @(negedge clk);
    expect_out("reset", 8'h00, 3'd0, 1'b0);
    areset = 1'b0;
    tick();
    expect_out("first", 8'h01, 3'd0, 1'b0);

    // 2: rotation with done one cycle after each grant
    for (int k = 0; k < 8; k++) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      expect_out("rot_idle", 8'h00, 3'd0, 1'b0);
      tick();
      nxt = 3'(k + 1);
      expect_out("rot_grant", 8'h01 << nxt, nxt, 1'b0);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("rot_end", 8'h00, 3'd0, 1'b0);

    // 3: wrap -- owner 5 then req 0x21 from ptr 6 picks 0
    req = 8'h20;
    tick();
    expect_out("wrap_own5", 8'h20, 3'd5, 1'b0);
    req  = 8'h21;
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("wrap_idle", 8'h00, 3'd0, 1'b0);
    tick();
    expect_out("wrap_grant", 8'h01, 3'd0, 1'b0);
    req  = 8'h03;
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("wrap_rel", 8'h00, 3'd0, 1'b0);
    tick();
    expect_out("wrap_ptr1", 8'h02, 3'd1, 1'b0);

    // 4: request drop releases without timeout, pointer moves past owner
    req = 8'h08;
    tick();
    expect_out("drop1_rel", 8'h00, 3'd0, 1'b0);
    tick();
    expect_out("drop_own3", 8'h08, 3'd3, 1'b0);
    req = 8'h11;
    tick();
    expect_out("drop_rel", 8'h00, 3'd0, 1'b0);
    tick();
    expect_out("drop_ptr4", 8'h10, 3'd4, 1'b0);

    // 5: timeout after 16 held cycles
    req = 8'h04;
    tick();
    expect_out("to_rel4", 8'h00, 3'd0, 1'b0);
    tick();
    expect_out("to_grant", 8'h04, 3'd2, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      expect_out("to_hold", 8'h04, 3'd2, 1'b0);
    end
    tick();
    expect_out("to_fire", 8'h00, 3'd0, 1'b1);
    tick();
    expect_out("to_regrant", 8'h04, 3'd2, 1'b0);

    // 6a: done on the timeout edge suppresses the timeout pulse
    for (int i = 0; i < 15; i++) tick();
    expect_out("coll_hold", 8'h04, 3'd2, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_out("coll_rel", 8'h00, 3'd0, 1'b0);
    tick();
    expect_out("coll_regrant", 8'h04, 3'd2, 1'b0);

    // 6b: asynchronous reset mid-grant, pointer returns to 0
    #2;
    areset = 1'b1;
    req    = 8'h81;
    #1;
    expect_out("areset_mid", 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    tick();
    expect_out("areset_ptr0", 8'h01, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
